// File: rtl/ring_deframer_pkg.sv
// Shared constants and state encoding for the ring deframer
// and anything else that talks to the ring buffer's serial link.
package ring_deframer_pkg;

    localparam int         RD_WORD_W    = 8;
    localparam logic [7:0] RD_SYNC_WORD = 8'hA5;

    typedef enum logic [1:0] {
        RD_HUNT   = 2'd0,
        RD_VERIFY = 2'd1,
        RD_LOCKED = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rd_sync_fifo.sv
// Small synchronous FIFO; head word is read straight from storage,
// forced to zero while empty so idle outputs read clean.
module rd_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = empty ? '0 : mem[rp];

    // storage write; a full FIFO popping this cycle frees the tail slot
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wp] <= push_data;
        end
    end

    // pointers, occupancy and the drop pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (do_push) begin
                wp <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ring_deframer.sv
// Serial word assembler: hunts for the sync word, verifies and locks
// onto the frame, then queues data words toward the consumer.
module ring_deframer
    import ring_deframer_pkg::*;
#(
    parameter int                WORD_W      = RD_WORD_W,
    parameter logic [WORD_W-1:0] SYNC_WORD   = RD_SYNC_WORD,
    parameter int                FRAME_WORDS = 4,
    parameter int                LOCK_CNT    = 2,
    parameter int                MISS_MAX    = 2,
    parameter int                FIFO_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rxda,
    input  logic              outstrobe,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              locked,
    output logic              frame_err,
    output logic              overflow
);

    localparam int BW = $clog2(WORD_W);
    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    rd_state_e         state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d, sr_new;
    logic [BW-1:0]     bit_q, bit_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [HW-1:0]     hits_q, hits_d;
    logic [MW-1:0]     miss_q, miss_d;
    logic              ferr_q, ferr_d;
    logic              word_done;
    logic              sync_slot;
    logic              is_sync;
    logic              push;
    logic              fifo_empty;

    assign sr_new    = {sr_q[WORD_W-2:0], rxda};
    assign word_done = outstrobe && (bit_q == BW'(WORD_W - 1));
    assign sync_slot = (wcnt_q == CW'(FRAME_WORDS));
    assign is_sync   = (sr_new == SYNC_WORD);

    // state register and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RD_HUNT;
            sr_q    <= '0;
            bit_q   <= '0;
            wcnt_q  <= '0;
            hits_q  <= '0;
            miss_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            wcnt_q  <= wcnt_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            ferr_q  <= ferr_d;
        end
    end

    // next state: hunt bit-by-bit, then judge each sync slot
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        wcnt_d  = wcnt_q;
        hits_d  = hits_q;
        miss_d  = miss_q;
        ferr_d  = 1'b0;
        if (outstrobe) begin
            sr_d  = sr_new;
            bit_d = word_done ? '0 : bit_q + BW'(1);
        end
        unique case (state_q)
            RD_HUNT: begin
                if (outstrobe && is_sync) begin
                    state_d = RD_VERIFY;
                    bit_d   = '0;
                    wcnt_d  = '0;
                    hits_d  = HW'(1);
                end
            end
            RD_VERIFY: begin
                if (word_done && !sync_slot) begin
                    wcnt_d = wcnt_q + CW'(1);
                end else if (word_done) begin
                    wcnt_d = '0;
                    if (is_sync) begin
                        hits_d = hits_q + HW'(1);
                        if (hits_q == HW'(LOCK_CNT - 1)) begin
                            state_d = RD_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RD_HUNT;
                    end
                end
            end
            RD_LOCKED: begin
                if (word_done && !sync_slot) begin
                    wcnt_d = wcnt_q + CW'(1);
                end else if (word_done) begin
                    wcnt_d = '0;
                    if (is_sync) begin
                        miss_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                        miss_d = miss_q + MW'(1);
                        if (miss_q == MW'(MISS_MAX - 1)) begin
                            state_d = RD_HUNT;
                        end
                    end
                end
            end
            default: state_d = RD_HUNT;
        endcase
    end

    // outputs: data-slot words go to the FIFO only while locked
    always_comb begin
        push      = (state_q == RD_LOCKED) && word_done && !sync_slot;
        locked    = (state_q == RD_LOCKED);
        frame_err = ferr_q;
    end

    assign word_valid = !fifo_empty;

    rd_sync_fifo #(
        .WIDTH(WORD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(sr_new),
        .pop      (word_ready),
        .head     (word_data),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_ring_deframer.sv
// Directed bench for ring_deframer: lock, hunt recovery, sync misses,
// FIFO overflow/drain, mid-word reset and sparse strobes.
module tb_ring_deframer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rxda = 1'b0;
    logic       outstrobe = 1'b0;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready = 1'b1;
    logic       locked;
    logic       frame_err;
    logic       overflow;

    int nvec = 0;
    int nerr = 0;
    bit slow = 1'b0;

    ring_deframer dut (
        .clock     (clock),
        .reset     (reset),
        .rxda      (rxda),
        .outstrobe (outstrobe),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .locked    (locked),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit pop_now);
        if (slow) begin
            repeat (2) begin
                @(negedge clock);
                rxda = ~rxda;
            end
        end
        @(negedge clock);
        rxda = b;
        outstrobe = 1'b1;
        if (pop_now) word_ready = 1'b1;
        @(posedge clock);
        #1;
        outstrobe = 1'b0;
        if (pop_now) word_ready = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit pop_last = 1'b0);
        for (int i = 7; i >= 0; i--) send_bit(w[i], pop_last && (i == 0));
    endtask

    task automatic data_word(input logic [7:0] w, input string tag);
        send_word(w);
        chk({tag, "_valid"}, word_valid, 1);
        chk({tag, "_data"}, word_data, w);
    endtask

    task automatic sync_word(input logic [7:0] w, input logic e,
                             input logic l, input string tag);
        send_word(w);
        chk({tag, "_ferr"}, frame_err, e);
        chk({tag, "_lock"}, locked, l);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk({tag, "_valid"}, word_valid, 0);
        chk({tag, "_data"}, word_data, 0);
        chk({tag, "_lock"}, locked, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_ovf"}, overflow, 0);
        reset = 1'b0;
    endtask

    task automatic test_lock(input string tag);
        sync_word(8'hA5, 0, 0, {tag, "_hunt"});
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        chk({tag, "_verify_valid"}, word_valid, 0);
        chk({tag, "_verify_lock"}, locked, 0);
        sync_word(8'hA5, 0, 1, {tag, "_lock"});
        data_word(8'h55, {tag, "_d55"});
        data_word(8'h66, {tag, "_d66"});
        data_word(8'h77, {tag, "_d77"});
        data_word(8'h88, {tag, "_d88"});
        sync_word(8'hA5, 0, 1, {tag, "_sync3"});
        chk({tag, "_sync3_valid"}, word_valid, 0);
    endtask

    initial begin
        logic [7:0] ow [6];
        logic [7:0] pw [5];
        ow = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        pw = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};

        // 1: reset, hunt, verify, lock, deliver
        do_reset("rst1");
        test_lock("t1");

        // 2: sync at bit offset 3, bad sync slot, recover
        do_reset("rst2");
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        sync_word(8'hA5, 0, 0, "t2_hunt");
        send_word(8'h3C);
        send_word(8'hC3);
        send_word(8'h5A);
        send_word(8'h0F);
        chk("t2_verify_valid", word_valid, 0);
        sync_word(8'h00, 1, 0, "t2_badsync");
        @(posedge clock);
        #1;
        chk("t2_ferr_single", frame_err, 0);
        sync_word(8'hA5, 0, 0, "t2_rehunt");
        send_word(8'h12);
        send_word(8'h34);
        send_word(8'h56);
        send_word(8'h78);
        sync_word(8'hA5, 0, 1, "t2_relock");

        // 3: single misses tolerated, two in a row drop lock
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) begin
                data_word(8'(f * 4 + k + 1), $sformatf("t3_f%0d_w%0d", f, k));
            end
            unique case (f)
                0: sync_word(8'hA4, 1, 1, "t3_miss1");
                1: sync_word(8'hA5, 0, 1, "t3_hit");
                2: sync_word(8'hA4, 1, 1, "t3_miss2");
                default: sync_word(8'hA4, 1, 0, "t3_miss3");
            endcase
        end
        chk("t3_unlocked_valid", word_valid, 0);

        // 4: relock, stall consumer, overflow, drain
        sync_word(8'hA5, 0, 0, "t4_hunt");
        send_word(8'h01);
        send_word(8'h02);
        send_word(8'h03);
        send_word(8'h04);
        sync_word(8'hA5, 0, 1, "t4_lock");
        word_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_word(ow[k]);
            chk($sformatf("t4_fill%0d_head", k), word_data, 8'hC1);
            chk($sformatf("t4_fill%0d_ovf", k), overflow, 0);
        end
        chk("t4_full_valid", word_valid, 1);
        sync_word(8'hA5, 0, 1, "t4_sync");
        send_word(ow[4]);
        chk("t4_w5_ovf", overflow, 1);
        send_word(ow[5]);
        chk("t4_w6_ovf", overflow, 1);
        chk("t4_w6_head", word_data, 8'hC1);
        @(posedge clock);
        #1;
        chk("t4_ovf_clear", overflow, 0);
        word_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_drain%0d_valid", k), word_valid, 1);
            chk($sformatf("t4_drain%0d_data", k), word_data, ow[k]);
            @(posedge clock);
            #1;
        end
        chk("t4_drained", word_valid, 0);

        // 5: reset mid-word with two words queued
        word_ready = 1'b0;
        send_word(8'hD7);
        send_word(8'hD8);
        chk("t5_queued_head", word_data, 8'hD7);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        do_reset("t5_rst");
        word_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("t5_gone_valid", word_valid, 0);
        chk("t5_gone_lock", locked, 0);

        // 6: sparse strobes with noisy idle bits, push+pop on full
        slow = 1'b1;
        test_lock("t6");
        word_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_word(pw[k]);
        sync_word(8'hA5, 0, 1, "t6_sync");
        send_word(pw[4], 1'b1);
        chk("t6_pp_ovf", overflow, 0);
        chk("t6_pp_head", word_data, 8'hE2);
        word_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("t6_drain%0d_data", k), word_data, pw[k]);
            @(posedge clock);
            #1;
        end
        chk("t6_drained", word_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
